// File: rtl/tiny8_ctrl_fsm.sv
// tiny8 multicycle control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with HALT and sticky FAULT.
// Define TINY8_CTRL_PERF_CNT_EN to add the saturating retired-instruction counter output.
module tiny8_ctrl_fsm #(
  parameter int EXEC_CYCLES = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_resp,
  input  logic              op_mem_rd,
  input  logic              op_mem_wr,
  input  logic              op_wb,
  input  logic              op_long,
  input  logic              op_halt,
  input  logic              resume,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_addr_sel,
  output logic              load_ir,
  output logic              load_pc,
  output logic              alu_en,
  output logic              load_regfile,
  output logic              halted,
  output logic              fault,
  output logic [2:0]        state_o
`ifdef TINY8_CTRL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] retired
`endif
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_FAULT     = 3'd6
  } state_e;

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int EXEC_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [EXEC_W-1:0] EXEC_LAST  = EXEC_W'(EXEC_CYCLES - 1);

  if (EXEC_CYCLES < 1 || PERF_W < 1) begin : g_bad_param
    $error("tiny8_ctrl_fsm: EXEC_CYCLES and PERF_W must be >= 1");
  end

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [EXEC_W-1:0] exec_q, exec_d;
  logic              mem_op, exec_done, timeout;

  assign mem_op    = op_mem_rd | op_mem_wr;
  assign exec_done = !op_long || (exec_q == EXEC_LAST);
  // A response in the limit cycle is checked first, so it still counts as success.
  assign timeout   = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LIMIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_resp)     state_d = S_DECODE;
        else if (timeout) state_d = S_FAULT;
      end
      S_DECODE: begin
        if (op_halt)                     state_d = S_HALT;
        else if (op_mem_rd && op_mem_wr) state_d = S_FAULT;
        else                             state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (exec_done) begin
          if (mem_op)     state_d = S_MEMORY;
          else if (op_wb) state_d = S_WRITEBACK;
          else            state_d = S_FETCH;
        end
      end
      S_MEMORY: begin
        if (mem_resp)     state_d = op_mem_rd ? S_WRITEBACK : S_FETCH;
        else if (timeout) state_d = S_FAULT;
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      if (resume) state_d = S_FETCH;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_FAULT;
    endcase
  end

  // Counters run only while staying in their state; any state change clears them.
  always_comb begin
    wait_d = '0;
    exec_d = '0;
    if (state_d == state_q && (state_q == S_FETCH || state_q == S_MEMORY))
      wait_d = wait_q + WAIT_W'(1);
    if (state_d == state_q && state_q == S_EXECUTE)
      exec_d = exec_q + EXEC_W'(1);
  end

`ifdef TINY8_CTRL_PERF_CNT_EN
  logic [PERF_W-1:0] ret_q;
  logic              retire;
  assign retire  = (state_d == S_FETCH) &&
                   (state_q == S_EXECUTE || state_q == S_MEMORY || state_q == S_WRITEBACK);
  assign retired = rst ? '0 : ret_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      exec_q  <= '0;
`ifdef TINY8_CTRL_PERF_CNT_EN
      ret_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      exec_q  <= exec_d;
`ifdef TINY8_CTRL_PERF_CNT_EN
      if (retire && ret_q != '1) ret_q <= ret_q + PERF_W'(1);
`endif
    end
  end

  // Moore decode, forced quiet while rst is high regardless of the held state.
  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    load_ir      = 1'b0;
    load_pc      = 1'b0;
    alu_en       = 1'b0;
    load_regfile = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;
    state_o      = 3'd0;
    if (!rst) begin
      state_o = state_q;
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          load_ir  = mem_resp;
        end
        S_DECODE:    load_pc = 1'b1;
        S_EXECUTE:   alu_en  = 1'b1;
        S_MEMORY: begin
          mem_addr_sel = 1'b1;
          mem_read     = op_mem_rd;
          mem_write    = op_mem_wr;
        end
        S_WRITEBACK: load_regfile = 1'b1;
        S_HALT:      halted = 1'b1;
        S_FAULT:     fault  = 1'b1;
        default:     fault  = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny8_ctrl_fsm.sv
// Randomized bench for tiny8_ctrl_fsm: each instruction is expanded into an expected
// per-cycle trace (state, strobes, retired count) and replayed against the DUT.
module tb_tiny8_ctrl_fsm;
  localparam int EXEC_CYCLES = 4;
  localparam int MEM_TIMEOUT = 16;
  localparam int PERF_W      = 4;
  localparam int RET_MAX     = (1 << PERF_W) - 1;
  localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4, S_H = 5, S_X = 6;

  // outs bit order: rd wr sel ir pc alu rf halted fault
  localparam bit [8:0] O_FETCH = 9'b100000000;
  localparam bit [8:0] O_FIR   = 9'b100100000;
  localparam bit [8:0] O_DEC   = 9'b000010000;
  localparam bit [8:0] O_EXE   = 9'b000001000;
  localparam bit [8:0] O_WB    = 9'b000000100;
  localparam bit [8:0] O_HALT  = 9'b000000010;
  localparam bit [8:0] O_FLT   = 9'b000000001;

  logic clk = 1'b0;
  logic rst, mem_resp, op_mem_rd, op_mem_wr, op_wb, op_long, op_halt, resume;
  logic mem_read, mem_write, mem_addr_sel, load_ir, load_pc, alu_en, load_regfile, halted, fault;
  logic [2:0] state_o;
`ifdef TINY8_CTRL_PERF_CNT_EN
  logic [PERF_W-1:0] retired;
`endif

  always #5 clk = ~clk;

  tiny8_ctrl_fsm #(.EXEC_CYCLES(EXEC_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst), .mem_resp(mem_resp),
    .op_mem_rd(op_mem_rd), .op_mem_wr(op_mem_wr), .op_wb(op_wb), .op_long(op_long),
    .op_halt(op_halt), .resume(resume),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr_sel(mem_addr_sel),
    .load_ir(load_ir), .load_pc(load_pc), .alu_en(alu_en), .load_regfile(load_regfile),
    .halted(halted), .fault(fault), .state_o(state_o)
`ifdef TINY8_CTRL_PERF_CNT_EN
    , .retired(retired)
`endif
  );

  typedef struct {
    bit       rst, resp, res;
    bit [4:0] flags;  // rd wr wb long halt
    int       st;
    bit [8:0] outs;
    int       ret;
  } cyc_t;

  cyc_t     tr[$];
  int       total = 0;
  int       bad   = 0;
  int       exp_ret = 0;
  bit [4:0] cur_flags;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // noisy: flags are not sampled in this cycle, so scramble them
  task automatic push(input int st, input bit [8:0] o, input bit resp, input bit res,
                      input bit noisy, input bit r);
    cyc_t c;
    c.rst   = r;
    c.resp  = resp;
    c.res   = res;
    c.flags = noisy ? 5'($urandom) : cur_flags;
    c.st    = st;
    c.outs  = o;
    c.ret   = exp_ret;
    tr.push_back(c);
  endtask

  task automatic do_reset(input int n);
    exp_ret = 0;
    for (int i = 0; i < n; i++) push(S_F, 9'h000, rb(), rb(), 1'b1, 1'b1);
  endtask

  task automatic fault_tail();
    for (int i = 0; i < 3; i++) push(S_X, O_FLT, rb(), rb(), 1'b1, 1'b0);
    do_reset(1);
  endtask

  task automatic retire();
    exp_ret = (exp_ret == RET_MAX) ? RET_MAX : exp_ret + 1;
  endtask

  // One instruction: df/dm = idle cycles before mem_resp in FETCH/MEMORY, hc = HALT cycles before resume.
  task automatic instr(input int df, input bit rd, input bit wr, input bit wb, input bit lng,
                       input bit hlt, input int dm, input int hc);
    int nf, nm, ne;
    cur_flags = {rd, wr, wb, lng, hlt};
    nf = (df > MEM_TIMEOUT) ? MEM_TIMEOUT + 1 : df;
    for (int i = 0; i < nf; i++) push(S_F, O_FETCH, 1'b0, rb(), 1'b1, 1'b0);
    if (df > MEM_TIMEOUT) begin fault_tail(); return; end
    push(S_F, O_FIR, 1'b1, rb(), 1'b1, 1'b0);
    push(S_D, O_DEC, rb(), rb(), 1'b0, 1'b0);
    if (hlt) begin
      for (int i = 0; i < hc; i++) push(S_H, O_HALT, rb(), 1'b0, 1'b1, 1'b0);
      push(S_H, O_HALT, rb(), 1'b1, 1'b1, 1'b0);
      return;
    end
    if (rd && wr) begin fault_tail(); return; end
    ne = lng ? EXEC_CYCLES : 1;
    for (int i = 0; i < ne; i++) push(S_E, O_EXE, rb(), rb(), 1'b0, 1'b0);
    if (rd || wr) begin
      nm = (dm > MEM_TIMEOUT) ? MEM_TIMEOUT + 1 : dm;
      for (int i = 0; i < nm; i++) push(S_M, {rd, wr, 7'b1000000}, 1'b0, rb(), 1'b0, 1'b0);
      if (dm > MEM_TIMEOUT) begin fault_tail(); return; end
      push(S_M, {rd, wr, 7'b1000000}, 1'b1, rb(), 1'b0, 1'b0);
      if (rd) push(S_W, O_WB, rb(), rb(), 1'b1, 1'b0);
    end else if (wb) begin
      push(S_W, O_WB, rb(), rb(), 1'b1, 1'b0);
    end
    retire();
  endtask

  task automatic play();
    cyc_t c;
    while (tr.size() > 0) begin
      c = tr.pop_front();
      @(posedge clk);
      #2;
      rst = c.rst; mem_resp = c.resp; resume = c.res;
      {op_mem_rd, op_mem_wr, op_wb, op_long, op_halt} = c.flags;
      #4;
      chk("state", int'(state_o), c.st);
      chk("outs", int'({mem_read, mem_write, mem_addr_sel, load_ir, load_pc, alu_en,
                        load_regfile, halted, fault}), int'(c.outs));
`ifdef TINY8_CTRL_PERF_CNT_EN
      chk("retired", int'(retired), c.ret);
`endif
    end
  endtask

  initial begin
    int df, dm, hc;
    bit rd, wr;
    rst = 1'b1; mem_resp = 1'b0; resume = 1'b0;
    op_mem_rd = 1'b0; op_mem_wr = 1'b0; op_wb = 1'b0; op_long = 1'b0; op_halt = 1'b0;
    cur_flags = '0;

    do_reset(2);
    instr(2, 0, 0, 1, 0, 0, 0, 0);             // ALU + writeback, 0,0,0,1,2,4
    instr(0, 0, 0, 0, 1, 0, 0, 0);             // long op, no writeback
    instr(1, 1, 0, 1, 0, 0, 3, 0);             // load, memory resp after 3 cycles
    instr(0, 0, 1, 0, 1, 0, 0, 0);             // store after long execute
    instr(MEM_TIMEOUT, 0, 0, 1, 0, 0, 0, 0);   // resp in the limit cycle still wins
    instr(0, 1, 0, 0, 0, 0, MEM_TIMEOUT, 0);
    instr(0, 0, 0, 0, 0, 1, 0, 10);            // HALT held, then resume
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    instr(MEM_TIMEOUT + 4, 0, 0, 0, 0, 0, 0, 0); // FETCH timeout -> FAULT -> rst
    instr(0, 1, 1, 0, 0, 0, 0, 0);             // illegal rd+wr -> FAULT -> rst
    instr(0, 0, 1, 0, 0, 0, MEM_TIMEOUT + 1, 0); // MEMORY timeout
    for (int i = 0; i < RET_MAX + 4; i++) instr(0, 0, 0, rb(), 0, 0, 0, 0); // counter saturation
    play();

    for (int n = 0; n < 160; n++) begin
      df = ($urandom_range(0, 15) == 0) ? $urandom_range(MEM_TIMEOUT, MEM_TIMEOUT + 3)
                                        : $urandom_range(0, 4);
      dm = ($urandom_range(0, 15) == 0) ? $urandom_range(MEM_TIMEOUT, MEM_TIMEOUT + 3)
                                        : $urandom_range(0, 4);
      hc = $urandom_range(0, 4);
      rd = rb();
      wr = rd ? ($urandom_range(0, 7) == 0) : rb();
      instr(df, rd, wr, rb(), rb(), $urandom_range(0, 9) == 0, dm, hc);
      play();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
